// File: rtl/led_bounce_ctrl.sv
// Bouncing-marker controller: one marker sweeps the LED bar, blinking in the edge
// zones and punching a hole in the lit middle band; optional hex readout and freeze.
//
// state  | meaning
// IDLE   | static band with dark HOLE_POS, waiting for a start edge
// RUN_R  | marker stepping toward LED0
// RUN_L  | marker stepping toward LED[N_LEDS-1]
// FROZEN | latched end state, left only through reset
module led_bounce_ctrl #(
    parameter int N_LEDS        = 16,
    parameter int START_POS     = 8,
    parameter int ZONE_LO       = 2,
    parameter int ZONE_HI       = 12,
    parameter int HOLE_POS      = 8,
    parameter int STEP_R_CYC    = 65000000,
    parameter int STEP_L_CYC    = 130000000,
    parameter int BLINK_LO_HALF = 9090909,
    parameter int BLINK_HI_HALF = 20000000,
    parameter int REFRESH_CYC   = 100000,
    localparam int POS_W        = $clog2(N_LEDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              freeze,
    input  logic              show_en,
    output logic [N_LEDS-1:0] led,
    output logic [3:0]        an,
    output logic [7:0]        seg,
    output logic [POS_W-1:0]  pos,
    output logic              dir,
    output logic [7:0]        bounces,
    output logic              frozen
);
    localparam int STEP_MAX = (STEP_R_CYC > STEP_L_CYC) ? STEP_R_CYC : STEP_L_CYC;
    localparam int STEP_W   = $clog2(STEP_MAX + 1);
    localparam int BLO_W    = $clog2(BLINK_LO_HALF + 1);
    localparam int BHI_W    = $clog2(BLINK_HI_HALF + 1);
    localparam int REF_W    = $clog2(REFRESH_CYC + 1);

    function automatic logic [N_LEDS-1:0] band_mask();
        logic [N_LEDS-1:0] m;
        m = '0;
        for (int i = 0; i < N_LEDS; i++)
            if (i >= ZONE_LO && i <= ZONE_HI) m[i] = 1'b1;
        return m;
    endfunction

    localparam logic [N_LEDS-1:0] BAND     = band_mask();
    localparam logic [N_LEDS-1:0] IDLE_PAT = BAND & ~(N_LEDS'(1) << HOLE_POS);

    function automatic logic [7:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hA7;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, RUN_R, RUN_L, FROZEN} state_t;

    state_t             state, state_nxt;
    logic [1:0]         rst_sync;
    logic               rst_i_n;
    logic               start_q, start_vld, start_edge;
    logic [STEP_W-1:0]  step_cnt, step_lim;
    logic               step_tick;
    logic [POS_W-1:0]   pos_q, pos_nxt;
    logic               dir_q, dir_nxt;
    logic [7:0]         bnc_q, bnc_nxt;
    logic [BLO_W-1:0]   blo_cnt;
    logic [BHI_W-1:0]   bhi_cnt;
    logic               blo_ph, bhi_ph;
    logic [REF_W-1:0]   ref_cnt;
    logic               scan_slot;
    logic [N_LEDS-1:0]  led_q, led_nxt;
    logic [3:0]         an_q, an_nxt;
    logic [7:0]         seg_q, seg_nxt;
    logic [7:0]         pos_ext;
    int                 pos_i;
    logic               in_band, below;

    // Assert immediately, release two clocks later so deassertion is synchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i_n = rst_sync[1];

    // start_vld blocks a bogus edge when start is already high as reset releases.
    assign start_edge = start & ~start_q & start_vld;
    assign step_lim   = (state == RUN_L) ? STEP_W'(STEP_L_CYC - 1) : STEP_W'(STEP_R_CYC - 1);
    assign step_tick  = ((state == RUN_R) || (state == RUN_L)) && (step_cnt == step_lim);

    assign pos_i   = int'(pos_q);
    assign in_band = (pos_i >= ZONE_LO) && (pos_i <= ZONE_HI);
    assign below   = (pos_i < ZONE_LO);
    assign pos_ext = 8'(pos_q);

    always_comb begin
        state_nxt = state;
        pos_nxt   = pos_q;
        dir_nxt   = dir_q;
        bnc_nxt   = bnc_q;
        case (state)
            IDLE: begin
                if (freeze)          state_nxt = FROZEN;
                else if (start_edge) state_nxt = RUN_R;
            end
            RUN_R: begin
                if (freeze) state_nxt = FROZEN;
                else if (step_tick) begin
                    if (pos_q != '0) pos_nxt = pos_q - POS_W'(1);
                    else begin
                        state_nxt = RUN_L;
                        dir_nxt   = 1'b1;
                        bnc_nxt   = (bnc_q == 8'hFF) ? 8'hFF : bnc_q + 8'd1;
                    end
                end
            end
            RUN_L: begin
                if (freeze) state_nxt = FROZEN;
                else if (step_tick) begin
                    if (pos_q != POS_W'(N_LEDS - 1)) pos_nxt = pos_q + POS_W'(1);
                    else begin
                        state_nxt = RUN_R;
                        dir_nxt   = 1'b0;
                        bnc_nxt   = (bnc_q == 8'hFF) ? 8'hFF : bnc_q + 8'd1;
                    end
                end
            end
            FROZEN:  state_nxt = FROZEN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        led_nxt = BAND;
        if (in_band)    led_nxt[pos_q] = 1'b0;
        else if (below) led_nxt[pos_q] = blo_ph;
        else            led_nxt[pos_q] = bhi_ph;
    end

    always_comb begin
        an_nxt  = 4'b1111;
        seg_nxt = 8'hFF;
        if (state == FROZEN) begin
            an_nxt  = in_band ? 4'b1001 : 4'b0110;
            seg_nxt = in_band ? 8'hA7 : 8'h86;
        end else if (show_en) begin
            if (N_LEDS > 16 && scan_slot) begin
                an_nxt  = 4'b1101;
                seg_nxt = hex7(pos_ext[7:4]);
            end else begin
                an_nxt  = 4'b1110;
                seg_nxt = hex7(pos_ext[3:0]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            start_vld <= 1'b0;
            step_cnt  <= '0;
            pos_q     <= POS_W'(START_POS);
            dir_q     <= 1'b0;
            bnc_q     <= 8'd0;
            blo_cnt   <= '0;
            bhi_cnt   <= '0;
            blo_ph    <= 1'b0;
            bhi_ph    <= 1'b0;
            ref_cnt   <= '0;
            scan_slot <= 1'b0;
            led_q     <= IDLE_PAT;
            an_q      <= 4'b1111;
            seg_q     <= 8'hFF;
        end else begin
            state     <= state_nxt;
            start_q   <= start;
            start_vld <= 1'b1;
            pos_q     <= pos_nxt;
            dir_q     <= dir_nxt;
            bnc_q     <= bnc_nxt;
            an_q      <= an_nxt;
            seg_q     <= seg_nxt;
            if (state_nxt != state || step_tick) step_cnt <= '0;
            else if (state == RUN_R || state == RUN_L) step_cnt <= step_cnt + STEP_W'(1);
            if (state != FROZEN) begin
                if (blo_cnt == BLO_W'(BLINK_LO_HALF - 1)) begin
                    blo_cnt <= '0;
                    blo_ph  <= ~blo_ph;
                end else blo_cnt <= blo_cnt + BLO_W'(1);
                if (bhi_cnt == BHI_W'(BLINK_HI_HALF - 1)) begin
                    bhi_cnt <= '0;
                    bhi_ph  <= ~bhi_ph;
                end else bhi_cnt <= bhi_cnt + BHI_W'(1);
            end
            if (ref_cnt == REF_W'(REFRESH_CYC - 1)) begin
                ref_cnt   <= '0;
                scan_slot <= ~scan_slot;
            end else ref_cnt <= ref_cnt + REF_W'(1);
            if (state == IDLE)        led_q <= IDLE_PAT;
            else if (state != FROZEN) led_q <= led_nxt;
        end
    end

    assign led     = led_q;
    assign an      = an_q;
    assign seg     = seg_q;
    assign pos     = pos_q;
    assign dir     = dir_q;
    assign bounces = bnc_q;
    assign frozen  = (state == FROZEN);
endmodule

// File: tb/tb_led_bounce_ctrl.sv
// Bench for led_bounce_ctrl: expected marker moves are queued when start is driven
// and checked by a monitor as pos/dir/bounces change; per-scenario checks inline.
module tb_led_bounce_ctrl;
    localparam int N = 16;
    localparam int TR = 4;
    localparam int TL = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        freeze = 1'b0;
    logic        show_en = 1'b0;
    logic [N-1:0] led;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [3:0]  pos;
    logic        dir;
    logic [7:0]  bounces;
    logic        frozen;

    led_bounce_ctrl #(
        .N_LEDS(N), .START_POS(8), .ZONE_LO(2), .ZONE_HI(12), .HOLE_POS(8),
        .STEP_R_CYC(TR), .STEP_L_CYC(TL), .BLINK_LO_HALF(2), .BLINK_HI_HALF(3),
        .REFRESH_CYC(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .freeze(freeze), .show_en(show_en),
        .led(led), .an(an), .seg(seg), .pos(pos), .dir(dir), .bounces(bounces),
        .frozen(frozen)
    );

    typedef struct {
        int cyc;
        int p;
        int d;
        int b;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    bit  mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected trajectory from a start edge seen at posedge c0+1: first move TR cycles later,
    // one-period dwell at each end.
    function automatic void push_path(input int c0, input int lim);
        ev_t e;
        int t;
        for (int j = 1; j <= 8; j++) begin
            t = c0 + 1 + TR * j;
            if (t <= lim) begin e.cyc = t; e.p = 8 - j; e.d = 0; e.b = 0; exp_q.push_back(e); end
        end
        t = c0 + 1 + TR * 9;
        if (t <= lim) begin e.cyc = t; e.p = 0; e.d = 1; e.b = 1; exp_q.push_back(e); end
        for (int p = 1; p <= 15; p++) begin
            t = c0 + 1 + TR * 9 + TL * p;
            if (t <= lim) begin e.cyc = t; e.p = p; e.d = 1; e.b = 1; exp_q.push_back(e); end
        end
        t = c0 + 1 + TR * 9 + TL * 16;
        if (t <= lim) begin e.cyc = t; e.p = 15; e.d = 0; e.b = 2; exp_q.push_back(e); end
        for (int j = 1; j <= 14; j++) begin
            t = c0 + 1 + TR * 9 + TL * 16 + TR * j;
            if (t <= lim) begin e.cyc = t; e.p = 15 - j; e.d = 0; e.b = 2; exp_q.push_back(e); end
        end
    endfunction

    task automatic monitor_loop();
        int pp, pd, pb;
        ev_t e;
        pp = int'(pos); pd = int'(dir); pb = int'(bounces);
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                pp = int'(pos); pd = int'(dir); pb = int'(bounces);
            end else if (int'(pos) != pp || int'(dir) != pd || int'(bounces) != pb) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL move_unexpected cyc=%0d pos=%0d dir=%0d bounces=%0d, required no change",
                             cyc, pos, dir, bounces);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc == cyc && e.p == int'(pos) && e.d == int'(dir) && e.b == int'(bounces))
                        n_pass++;
                    else
                        $display("FAIL move got cyc=%0d pos=%0d dir=%0d b=%0d required cyc=%0d pos=%0d dir=%0d b=%0d",
                                 cyc, pos, dir, bounces, e.cyc, e.p, e.d, e.b);
                end
                pp = int'(pos); pd = int'(dir); pb = int'(bounces);
            end
        end
    endtask

    task automatic to_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL drain got %0d pending moves required 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic pulse_start(output int c0);
        @(posedge clk);
        #1 start = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1;
        #23;
        n_checks++;
        if (led !== 16'h1EFC || pos !== 4'd8 || dir !== 1'b0 || bounces !== 8'd0 || frozen !== 1'b0)
            $display("FAIL reset_state got led=%h pos=%0d dir=%b b=%0d fz=%b required 1efc 8 0 0 0",
                     led, pos, dir, bounces, frozen);
        else n_pass++;
        n_checks++;
        if (an !== 4'b1111 || seg !== 8'hFF) $display("FAIL reset_disp got an=%b seg=%h required 1111 ff", an, seg);
        else n_pass++;
        @(negedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (50) @(negedge clk);
        n_checks++;
        if (led !== 16'h1EFC || pos !== 4'd8 || an !== 4'hF || seg !== 8'hFF)
            $display("FAIL idle_held_start got led=%h pos=%0d an=%h seg=%h required 1efc 8 f ff", led, pos, an, seg);
        else n_pass++;
        start = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_sweep();
        int c0, mism, trans;
        logic s[12];
        pulse_start(c0);
        push_path(c0, c0 + 169);
        to_cyc(c0 + 13);
        show_en = 1'b1;
        to_cyc(c0 + 14);
        n_checks++;
        if (led !== 16'h1FDC) $display("FAIL run_led_pos5 got %h required 1fdc", led);
        else n_pass++;
        n_checks++;
        if (an !== 4'b1110 || seg !== 8'h92) $display("FAIL show_pos5 got an=%b seg=%h required 1110 92", an, seg);
        else n_pass++;
        show_en = 1'b0;
        to_cyc(c0 + 15);
        n_checks++;
        if (an !== 4'hF || seg !== 8'hFF) $display("FAIL show_off got an=%b seg=%h required 1111 ff", an, seg);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            to_cyc(c0 + 34 + i);
            s[i] = led[0];
            if (i == 1) begin
                n_checks++;
                if ((led & 16'hFFFE) !== 16'h1FFC) $display("FAIL band_pos0 got %h required 1ffc", led & 16'hFFFE);
                else n_pass++;
            end
        end
        mism = 0; trans = 0;
        for (int i = 0; i < 10; i++) if (s[i + 2] == s[i]) mism++;
        for (int i = 1; i < 12; i++) if (s[i] != s[i - 1]) trans++;
        n_checks++;
        if (mism != 0 || trans < 5 || trans > 6)
            $display("FAIL blink_lo got mism=%0d toggles=%0d required 0 and 5..6", mism, trans);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            to_cyc(c0 + 158 + i);
            s[i] = led[15];
        end
        mism = 0; trans = 0;
        for (int i = 0; i < 9; i++) if (s[i + 3] == s[i]) mism++;
        for (int i = 1; i < 12; i++) if (s[i] != s[i - 1]) trans++;
        n_checks++;
        if (mism != 0 || trans < 3 || trans > 4)
            $display("FAIL blink_hi got mism=%0d toggles=%0d required 0 and 3..4", mism, trans);
        else n_pass++;
        wait_drain(20);
    endtask

    task automatic test_freeze_idle();
        do_reset();
        @(negedge clk);
        freeze = 1'b1; start = 1'b1;
        @(negedge clk);
        freeze = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (frozen !== 1'b1 || pos !== 4'd8 || led !== 16'h1EFC)
            $display("FAIL freeze_beats_start got fz=%b pos=%0d led=%h required 1 8 1efc", frozen, pos, led);
        else n_pass++;
        n_checks++;
        if (an !== 4'b1001 || seg !== 8'hA7) $display("FAIL frozen_band_disp got an=%b seg=%h required 1001 a7", an, seg);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        show_en = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (frozen !== 1'b1 || pos !== 4'd8 || an !== 4'b1001 || seg !== 8'hA7 || bounces !== 8'd0)
            $display("FAIL frozen_hold got fz=%b pos=%0d an=%b seg=%h b=%0d required 1 8 1001 a7 0",
                     frozen, pos, an, seg, bounces);
        else n_pass++;
        show_en = 1'b0;
    endtask

    task automatic test_freeze_edge();
        int c0;
        logic l14;
        do_reset();
        pulse_start(c0);
        push_path(c0, c0 + 149);
        to_cyc(c0 + 150);
        freeze = 1'b1;
        to_cyc(c0 + 153);
        freeze = 1'b0;
        n_checks++;
        if (frozen !== 1'b1 || pos !== 4'd14 || dir !== 1'b1 || bounces !== 8'd1)
            $display("FAIL freeze14_state got fz=%b pos=%0d dir=%b b=%0d required 1 14 1 1", frozen, pos, dir, bounces);
        else n_pass++;
        n_checks++;
        if (an !== 4'b0110 || seg !== 8'h86) $display("FAIL frozen_edge_disp got an=%b seg=%h required 0110 86", an, seg);
        else n_pass++;
        n_checks++;
        if (led[13:0] !== 14'h1FFC || led[15] !== 1'b0)
            $display("FAIL frozen_led got %h required band 1ffc with led15=0", led);
        else n_pass++;
        l14 = led[14];
        repeat (20) @(negedge clk);
        n_checks++;
        if (led[14] !== l14 || pos !== 4'd14 || an !== 4'b0110)
            $display("FAIL frozen_led_hold got led14=%b pos=%0d an=%b required %b 14 0110", led[14], pos, an, l14);
        else n_pass++;
        wait_drain(5);
    endtask

    task automatic test_reset_mid_run();
        int c0, c1;
        do_reset();
        pulse_start(c0);
        push_path(c0, c0 + 45);
        to_cyc(c0 + 40);
        show_en = 1'b1;
        to_cyc(c0 + 50);
        n_checks++;
        if (an !== 4'b1110 || pos !== 4'd1 || dir !== 1'b1)
            $display("FAIL pre_reset got an=%b pos=%0d dir=%b required 1110 1 1", an, pos, dir);
        else n_pass++;
        mon_en = 1'b0;
        exp_q.delete();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (pos !== 4'd8 || dir !== 1'b0 || bounces !== 8'd0 || led !== 16'h1EFC || frozen !== 1'b0)
            $display("FAIL async_reset got pos=%0d dir=%b b=%0d led=%h fz=%b required 8 0 0 1efc 0",
                     pos, dir, bounces, led, frozen);
        else n_pass++;
        n_checks++;
        if (an !== 4'hF || seg !== 8'hFF) $display("FAIL async_reset_disp got an=%b seg=%h required 1111 ff", an, seg);
        else n_pass++;
        show_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        mon_en = 1'b1;
        pulse_start(c1);
        push_path(c1, c1 + 13);
        wait_drain(30);
    endtask

    initial begin
        fork
            monitor_loop();
        join_none
        test_reset();
        test_sweep();
        test_freeze_idle();
        test_freeze_edge();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
